// File: rtl/sha256_mmio_wrapper.sv
// Register-mapped front end for an external SHA-256 compression core.
// CPU words are assembled into 512-bit blocks, queued in a small FIFO and
// fed to the core one after another. Blocks after the first chain from the
// core's previous digest. The final digest, sticky status and an interrupt
// are exposed through the register map.
module sha256_mmio_wrapper #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wren,
  input  logic          rden,
  input  logic [AW-1:0] address,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          irq,
  output logic          core_start,
  output logic          core_init,
  output logic [511:0]  core_block,
  input  logic          core_done,
  input  logic [255:0]  core_digest
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_e;

  state_e          state_q, state_d;
  logic            init_q, irq_en_q, done_q, ovf_q, init_pend_q;
  logic [3:0]      wcnt_q;
  logic [7:0]      cnt_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [511:0]    stage_q, block_q;
  logic [511:0]    mem_q [DEPTH];
  logic [255:0]    digest_q;
  logic [31:0]     rdata_q, rd_mux;

  logic wr_ctrl, wr_status, wr_data, digest_sel;
  logic clr, start_req, commit, empty, full, push, start_ok, pop, busy;

  assign wr_ctrl    = wren && (address == AW'(0));
  assign wr_status  = wren && (address == AW'(1));
  assign wr_data    = wren && (address == AW'(2));
  assign digest_sel = (address[AW-1:3] == (AW-3)'(2));

  assign clr       = wr_ctrl && wdata[3];
  assign start_req = wr_ctrl && wdata[0];
  assign commit    = wr_data && (wcnt_q == 4'd15);
  assign empty     = (cnt_q == 8'd0);
  assign full      = (cnt_q == 8'(DEPTH));
  // A commit into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push      = commit && !full && !clr;
  assign start_ok  = start_req && !clr && (state_q == IDLE) && !empty;
  // The head is popped on the edge that enters LOAD, so core_block is
  // already valid while core_start is high.
  assign pop       = !clr && (start_ok || ((state_q == WAIT) && core_done && !empty));

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (core_done) state_d = empty ? FIN : LOAD;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // FSM outputs: start pulse, init flag for the first block, busy
  always_comb begin
    busy       = (state_q != IDLE);
    core_start = (state_q == LOAD);
    core_init  = (state_q == LOAD) && init_pend_q;
  end

  // Control bits, first-block init flag and sticky status (set beats W1C)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      init_pend_q <= 1'b0;
    end else begin
      if (wr_ctrl && !wdata[3]) begin
        init_q   <= wdata[1];
        irq_en_q <= wdata[2];
      end
      if (clr)                   init_pend_q <= 1'b0;
      else if (start_ok)         init_pend_q <= wdata[1];
      else if (state_q == LOAD)  init_pend_q <= 1'b0;
      if (clr)                        done_q <= 1'b0;
      else if (state_q == FIN)        done_q <= 1'b1;
      else if (wr_status && wdata[1]) done_q <= 1'b0;
      if (clr)                        ovf_q <= 1'b0;
      else if (commit && full)        ovf_q <= 1'b1;
      else if (wr_status && wdata[4]) ovf_q <= 1'b0;
    end
  end

  // Word staging plus FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      wcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_data) begin
        // Word k lands at bits [511-32k -: 32]; ~wcnt_q equals 15-k.
        stage_q[{~wcnt_q, 5'b0} +: 32] <= wdata;
        wcnt_q <= wcnt_q + 4'd1;
      end
      if (push) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 8'd1;
        2'b01:   cnt_q <= cnt_q - 8'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; the 16th word goes straight in alongside the staged 15
  always_ff @(posedge clk) begin
    // NOTE: the block memory has no reset; the pointers and count define
    // which entries are valid, so clearing the storage buys nothing.
    if (push) mem_q[wptr_q] <= {stage_q[511:32], wdata};
  end

  // Block presented to the core, held until the next pop
  always_ff @(posedge clk) begin
    if (!reset_n) block_q <= '0;
    else if (pop) block_q <= mem_q[rptr_q];
  end

  // Digest capture at the end of a message
  always_ff @(posedge clk) begin
    if (!reset_n)              digest_q <= '0;
    else if (clr)              digest_q <= '0;
    else if (state_q == FIN)   digest_q <= core_digest;
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_mux = 32'd0;
    if (address == AW'(0))      rd_mux = {28'd0, 1'b0, irq_en_q, init_q, 1'b0};
    else if (address == AW'(1)) rd_mux = {16'd0, cnt_q, 3'd0, ovf_q, empty, full, done_q, busy};
    else if (address == AW'(2)) rd_mux = {28'd0, wcnt_q};
    else if (digest_sel)        rd_mux = digest_q[{~address[2:0], 5'b0} +: 32];
  end

  // Registered read data, held while rden is low
  always_ff @(posedge clk) begin
    if (!reset_n)  rdata_q <= '0;
    else if (rden) rdata_q <= rd_mux;
  end

  assign rdata      = rdata_q;
  assign irq        = done_q & irq_en_q;
  assign core_block = block_q;

endmodule

// File: tb/tb_sha256_mmio_wrapper.sv
// Directed bench for sha256_mmio_wrapper. A behavioural SHA-256 core answers
// each core_start with a real compression after a programmable latency, so
// the published test-vector digests are the expected values.
module tb_sha256_mmio_wrapper;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wren = 1'b0;
  logic         rden = 1'b0;
  logic [4:0]   address = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         irq, core_start, core_init;
  logic [511:0] core_block;
  logic         core_done = 1'b0;
  logic [255:0] core_digest = '0;

  sha256_mmio_wrapper #(.DEPTH(4), .AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .wren(wren), .rden(rden),
    .address(address), .wdata(wdata), .rdata(rdata), .irq(irq),
    .core_start(core_start), .core_init(core_init), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- SHA-256 reference compression ----------------
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // ---------------- behavioural core ----------------
  int           lat = 4;
  int           cd = 0;
  int           cyc = 0;
  logic [255:0] model_h = '0;
  logic [255:0] model_res = '0;
  int           start_cyc [$];
  int           done_cyc [$];
  logic         start_init [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (!reset_n) begin
      cd = 0;
    end else if (core_start) begin
      start_cyc.push_back(cyc);
      start_init.push_back(core_init);
      model_res = sha_compress(core_init ? IV : model_h, core_block);
      cd = lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_done   = 1'b1;
        core_digest = model_res;
        model_h     = model_res;
        done_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- bus helpers ----------------
  int last_wr_cyc = 0;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wren = 1'b1; address = a; wdata = d;
    @(posedge clk);
    #1;
    wren = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    rden = 1'b1; address = a;
    @(posedge clk);
    #1;
    rden = 1'b0;
    d = rdata;
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic push_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) wr(5'd2, blk[511 - 32*i -: 32]);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < 300 && s[0]; i++) rd(5'd1, s);
    check(tag, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic clr_log();
    start_cyc.delete();
    done_cyc.delete();
    start_init.delete();
  endtask

  task automatic check_digest(input logic [255:0] exp, input string tag);
    for (int i = 0; i < 8; i++)
      rd_check(5'(16 + i), exp[255 - 32*i -: 32], $sformatf("%s_dig%0d", tag, i));
  endtask

  // ---------------- stimulus ----------------
  logic [511:0] abc_blk, two_b1, two_b2;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    two_b1  = '0;
    for (int i = 0; i < 14; i++) two_b1[511 - 32*i -: 32] = 32'h61626364 + 32'(i) * 32'h01010101;
    two_b1[511 - 32*14 -: 32] = 32'h80000000;
    two_b2  = {480'd0, 32'h000001c0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_start", {31'd0, core_start}, 32'd0);
    check("rst_init", {31'd0, core_init}, 32'd0);
    check("rst_block", {31'd0, |core_block}, 32'd0);
    rd_check(5'd1, 32'h00000008, "rst_status");
    rd_check(5'd2, 32'd0, "rst_wcnt");

    // Single-block "abc" with irq disabled
    push_block(abc_blk);
    rd_check(5'd1, 32'h00000100, "abc_queued");
    clr_log();
    wr(5'd0, 32'h3);
    wait_idle("abc_idle");
    check("abc_nstart", start_cyc.size(), 1);
    if (start_cyc.size() > 0) begin
      check("abc_start_lat", start_cyc[0], last_wr_cyc);
      check("abc_init", {31'd0, start_init[0]}, 32'd1);
    end
    check_digest(ABC_DIG, "abc");
    rd_check(5'd1, 32'h0000000a, "abc_status");
    check("abc_irq_off", {31'd0, irq}, 32'd0);
    wr(5'd0, 32'h4);
    check("abc_irq_on", {31'd0, irq}, 32'd1);
    rd_check(5'd0, 32'h4, "ctrl_read");
    wr(5'd1, 32'h2);
    check("abc_irq_w1c", {31'd0, irq}, 32'd0);

    // Start with an empty FIFO is ignored
    clr_log();
    wr(5'd0, 32'h1);
    repeat (5) @(posedge clk);
    check("empty_nstart", start_cyc.size(), 0);
    rd_check(5'd1, 32'h00000008, "empty_status");

    // Two-block message, chained
    push_block(two_b1);
    push_block(two_b2);
    rd_check(5'd1, 32'h00000200, "two_queued");
    clr_log();
    wr(5'd0, 32'h3);
    wait_idle("two_idle");
    check("two_nstart", start_cyc.size(), 2);
    check("two_ndone", done_cyc.size(), 2);
    if (start_cyc.size() == 2 && done_cyc.size() > 0) begin
      check("two_init0", {31'd0, start_init[0]}, 32'd1);
      check("two_init1", {31'd0, start_init[1]}, 32'd0);
      check("two_gap", start_cyc[1] - done_cyc[0], 1);
    end
    check_digest(TWO_DIG, "two");
    rd_check(5'd1, 32'h0000000a, "two_status");
    wr(5'd1, 32'h2);

    // Overflow: five commits into a four-deep FIFO, then a start while busy
    for (int b = 0; b < 5; b++) push_block(abc_blk);
    rd_check(5'd1, 32'h00000414, "ovf_status");
    rd_check(5'd2, 32'd0, "ovf_wcnt");
    clr_log();
    wr(5'd0, 32'h3);
    wr(5'd0, 32'h1);
    wait_idle("ovf_idle");
    check("ovf_nstart", start_cyc.size(), 4);
    rd_check(5'd1, 32'h0000001a, "ovf_after");
    wr(5'd1, 32'h10);
    rd_check(5'd1, 32'h0000000a, "ovf_w1c");
    wr(5'd1, 32'h2);
    rd_check(5'd1, 32'h00000008, "done_w1c");

    // Block pushed while the core is working gets chained
    lat = 40;
    push_block(abc_blk);
    clr_log();
    wr(5'd0, 32'h3);
    push_block(abc_blk);
    rd_check(5'd1, 32'h00000101, "pw_mid");
    wait_idle("pw_idle");
    check("pw_nstart", start_cyc.size(), 2);
    check("pw_ndone", done_cyc.size(), 2);
    if (start_init.size() == 2) check("pw_init1", {31'd0, start_init[1]}, 32'd0);
    rd_check(5'd1, 32'h0000000a, "pw_status");

    // Clear in the middle of WAIT; the late core_done is ignored
    lat = 20;
    push_block(abc_blk);
    for (int i = 0; i < 3; i++) wr(5'd2, 32'h11111111 * 32'(i + 1));
    clr_log();
    wr(5'd0, 32'h7);
    repeat (3) @(posedge clk);
    check("clr_irq_before", {31'd0, irq}, 32'd1);
    wr(5'd0, 32'hc);
    repeat (40) @(posedge clk);
    check("clr_ndone", done_cyc.size(), 1);
    rd_check(5'd1, 32'h00000008, "clr_status");
    rd_check(5'd16, 32'd0, "clr_dig0");
    rd_check(5'd23, 32'd0, "clr_dig7");
    rd_check(5'd2, 32'd0, "clr_wcnt");
    rd_check(5'd0, 32'h6, "clr_ctrl_kept");
    check("clr_irq", {31'd0, irq}, 32'd0);
    lat = 4;

    // Single block with irq enabled
    push_block(abc_blk);
    clr_log();
    wr(5'd0, 32'h7);
    wait_idle("irq_idle");
    check("irq_on", {31'd0, irq}, 32'd1);
    rd_check(5'd16, ABC_DIG[255:224], "irq_dig0");
    rd_check(5'd23, ABC_DIG[31:0], "irq_dig7");

    // Unmapped reads
    rd_check(5'd5, 32'd0, "unmapped5");
    rd_check(5'd24, 32'd0, "unmapped24");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
